// File: rtl/next_pc_unit.sv
// next_pc_unit: owns the architectural PC, resolves branches and jumps,
// runs the instruction-memory fetch handshake and produces the JAL link write.
// The control FSM walks IDLE -> FETCH -> DECODE -> FETCH ... and parks in
// HALT after a misaligned jump-register until the next reset.
module next_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  ctrl_sel,
  input  logic        branch_ne,
  input  logic        zero_flag,
  input  logic [15:0] imm16,
  input  logic [25:0] target26,
  input  logic [31:0] rs_value,
  input  logic        link_en,
  input  logic        instr_valid,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  output logic [31:0] pc,
  output logic        link_we,
  output logic [31:0] link_addr,
  output logic        jr_misalign,
  output logic [31:0] retired
);

  // next-PC select encodings
  localparam logic [1:0] SEL_SEQ    = 2'd0;
  localparam logic [1:0] SEL_JUMP   = 2'd1;
  localparam logic [1:0] SEL_BRANCH = 2'd2;
  localparam logic [1:0] SEL_JR     = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_DECODE = 2'd2,
    S_HALT   = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [31:0] r_pc;
  logic [31:0] r_retired;
  logic        r_jr_misalign;
  logic        r_link_we;
  logic [31:0] r_link_addr;

  logic [31:0] w_pc4;
  logic [31:0] w_br_offset;
  logic [31:0] w_br_target;
  logic [31:0] w_jump_target;
  logic        w_taken;
  logic [31:0] w_next_pc;
  logic        w_accept;
  logic        w_misalign;
  logic        w_commit;

  // Target formation: all additions are 32-bit and wrap modulo 2^32.
  assign w_pc4         = r_pc + 32'd4;
  assign w_br_offset   = {{14{imm16[15]}}, imm16, 2'b00};
  assign w_br_target   = w_pc4 + w_br_offset;
  assign w_jump_target = {w_pc4[31:28], target26, 2'b00};
  assign w_taken       = branch_ne ? ~zero_flag : zero_flag;

  // An instruction is accepted only while waiting in DECODE. A jr whose
  // target is not word-aligned is accepted but not committed: it halts.
  assign w_accept   = (r_state == S_DECODE) && instr_valid;
  assign w_misalign = (ctrl_sel == SEL_JR) && (rs_value[1:0] != 2'b00);
  assign w_commit   = w_accept && !w_misalign;

  // Select the next PC from the controller's 2-bit select.
  always_comb begin
    w_next_pc = w_pc4;
    case (ctrl_sel)
      SEL_SEQ:    w_next_pc = w_pc4;
      SEL_JUMP:   w_next_pc = w_jump_target;
      SEL_BRANCH: w_next_pc = w_taken ? w_br_target : w_pc4;
      SEL_JR:     w_next_pc = rs_value;
      default:    w_next_pc = w_pc4;
    endcase
  end

  // FSM state register; reset aborts any fetch or decode immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   w_state_nxt = S_FETCH;
      S_FETCH:  if (imem_ack) w_state_nxt = S_DECODE;
      S_DECODE: begin
        if (instr_valid) begin
          w_state_nxt = w_misalign ? S_HALT : S_FETCH;
        end
      end
      S_HALT:   w_state_nxt = S_HALT;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs: the fetch request is a pure decode of the state so that
  // an asynchronous reset drops it in the same cycle.
  always_comb begin
    imem_req = 1'b0;
    case (r_state)
      S_FETCH: imem_req = 1'b1;
      default: imem_req = 1'b0;
    endcase
  end

  // Architectural PC, retired-instruction counter and sticky jr error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc          <= RESET_PC;
      r_retired     <= 32'd0;
      r_jr_misalign <= 1'b0;
    end else begin
      if (w_commit) begin
        r_pc      <= w_next_pc;
        r_retired <= r_retired + 32'd1;
      end
      if (w_accept && w_misalign) begin
        r_jr_misalign <= 1'b1;
      end
    end
  end

  // JAL link write: one-cycle strobe, address held until the next link.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_link_we   <= 1'b0;
      r_link_addr <= 32'd0;
    end else begin
      r_link_we <= w_commit && link_en;
      if (w_commit && link_en) begin
        r_link_addr <= w_pc4;
      end
    end
  end

  assign imem_addr   = r_pc;
  assign pc          = r_pc;
  assign retired     = r_retired;
  assign jr_misalign = r_jr_misalign;
  assign link_we     = r_link_we;
  assign link_addr   = r_link_addr;

endmodule

// File: tb/tb_next_pc_unit.sv
// Directed bench for next_pc_unit: a reference PC model pushes every
// expected fetch address into a queue, and the fetch responder pops and
// compares it when the DUT raises imem_req.
module tb_next_pc_unit;

  localparam logic [31:0] RPC = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  ctrl_sel;
  logic        branch_ne;
  logic        zero_flag;
  logic [15:0] imm16;
  logic [25:0] target26;
  logic [31:0] rs_value;
  logic        link_en;
  logic        instr_valid;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] pc;
  logic        link_we;
  logic [31:0] link_addr;
  logic        jr_misalign;
  logic [31:0] retired;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_q[$];
  logic [31:0] m_pc;
  logic [31:0] m_ret;

  always #5 clk = ~clk;

  next_pc_unit #(.RESET_PC(RPC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ctrl_sel    (ctrl_sel),
    .branch_ne   (branch_ne),
    .zero_flag   (zero_flag),
    .imm16       (imm16),
    .target26    (target26),
    .rs_value    (rs_value),
    .link_en     (link_en),
    .instr_valid (instr_valid),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .pc          (pc),
    .link_we     (link_we),
    .link_addr   (link_addr),
    .jr_misalign (jr_misalign),
    .retired     (retired)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Serve one fetch: wait (bounded) for the request, compare the address
  // against the scoreboard, hold two cycles, then pulse ack.
  // With poke set, a stray instr_valid is driven during the fetch.
  task automatic do_fetch(input bit poke);
    int          n = 0;
    logic [31:0] e = 32'hDEAD_BEEF;
    while (imem_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk1("fetch_req", imem_req, 1'b1);
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $error("FAIL fetch_scoreboard: observed empty queue expected an entry");
    end else begin
      e = exp_q.pop_front();
    end
    chk("fetch_addr", imem_addr, e);
    if (poke) begin
      instr_valid = 1'b1;
      ctrl_sel    = 2'd3;
      rs_value    = 32'h1234_5678;
    end
    @(negedge clk);
    instr_valid = 1'b0;
    chk1("fetch_hold_req", imem_req, 1'b1);
    chk("fetch_hold_addr", imem_addr, e);
    if (poke) begin
      chk("poke_pc", pc, m_pc);
      chk("poke_retired", retired, m_ret);
    end
    imem_ack = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    chk1("req_drop_after_ack", imem_req, 1'b0);
  endtask

  // Present one instruction in DECODE and check its architectural effect.
  task automatic do_instr(input logic [1:0] sel, input logic bne, input logic zf,
                          input logic [15:0] imm, input logic [25:0] tgt,
                          input logic [31:0] rs, input logic lnk);
    logic [31:0] pc4;
    logic [31:0] nxt;
    logic [31:0] off;
    bit          halt;
    bit          tk;
    pc4  = m_pc + 32'd4;
    off  = {{16{imm[15]}}, imm};
    tk   = bne ? (zf == 1'b0) : (zf == 1'b1);
    halt = (sel == 2'd3) && (rs[1:0] != 2'b00);
    case (sel)
      2'd0:    nxt = pc4;
      2'd1:    nxt = {pc4[31:28], tgt, 2'b00};
      2'd2:    nxt = tk ? pc4 + off * 32'd4 : pc4;
      default: nxt = rs;
    endcase
    ctrl_sel    = sel;
    branch_ne   = bne;
    zero_flag   = zf;
    imm16       = imm;
    target26    = tgt;
    rs_value    = rs;
    link_en     = lnk;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    link_en     = 1'b0;
    if (!halt) begin
      m_pc  = nxt;
      m_ret = m_ret + 32'd1;
      exp_q.push_back(nxt);
    end
    chk("pc", pc, m_pc);
    chk("retired", retired, m_ret);
    chk1("jr_misalign", jr_misalign, halt);
    chk1("req_after_instr", imem_req, !halt);
    if (lnk && !halt) begin
      chk1("link_we_pulse", link_we, 1'b1);
      chk("link_addr", link_addr, pc4);
      @(negedge clk);
      chk1("link_we_drop", link_we, 1'b0);
      chk("link_addr_hold", link_addr, pc4);
    end else begin
      chk1("link_we_idle", link_we, 1'b0);
    end
  endtask

  initial begin
    rst_n = 1'b0; ctrl_sel = 2'd0; branch_ne = 1'b0; zero_flag = 1'b0;
    imm16 = 16'h0; target26 = 26'h0; rs_value = 32'h0; link_en = 1'b0;
    instr_valid = 1'b0; imem_ack = 1'b0;
    m_pc = RPC; m_ret = 32'd0;
    repeat (2) @(negedge clk);
    chk1("rst_req", imem_req, 1'b0);
    chk("rst_pc", pc, RPC);
    chk1("rst_link_we", link_we, 1'b0);
    chk("rst_link_addr", link_addr, 32'h0);
    chk1("rst_misalign", jr_misalign, 1'b0);
    chk("rst_retired", retired, 32'h0);

    // Release: one IDLE cycle, then fetch at the reset PC.
    exp_q.push_back(RPC);
    rst_n = 1'b1;
    #1 chk1("idle_no_req", imem_req, 1'b0);
    @(negedge clk);
    chk1("first_fetch_req", imem_req, 1'b1);
    do_fetch(1'b0);

    // Three sequential instructions.
    for (int i = 0; i < 3; i++) begin
      do_instr(2'd0, 1'b0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0);
      do_fetch(1'b0);
    end

    // BEQ taken backwards, BNE not taken, BNE taken forwards.
    do_instr(2'd3, 1'b0, 1'b0, 16'h0, 26'h0, 32'h0000_0100, 1'b0);
    do_fetch(1'b0);
    do_instr(2'd2, 1'b0, 1'b1, 16'hFFFE, 26'h0, 32'h0, 1'b0);
    do_fetch(1'b0);
    do_instr(2'd3, 1'b0, 1'b0, 16'h0, 26'h0, 32'h0000_0100, 1'b0);
    do_fetch(1'b0);
    do_instr(2'd2, 1'b1, 1'b1, 16'hFFFE, 26'h0, 32'h0, 1'b0);
    do_fetch(1'b0);
    do_instr(2'd2, 1'b1, 1'b0, 16'h0003, 26'h0, 32'h0, 1'b0);
    do_fetch(1'b0);

    // JAL from 0x1000_0010.
    do_instr(2'd3, 1'b0, 1'b0, 16'h0, 26'h0, 32'h1000_0010, 1'b0);
    do_fetch(1'b0);
    do_instr(2'd1, 1'b0, 1'b0, 16'h0, 26'h000_0040, 32'h0, 1'b1);
    do_fetch(1'b0);

    // PC wrap, with a stray instr_valid during the fetch at 0xFFFF_FFFC.
    do_instr(2'd3, 1'b0, 1'b0, 16'h0, 26'h0, 32'hFFFF_FFFC, 1'b0);
    do_fetch(1'b1);
    do_instr(2'd0, 1'b0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0);
    do_fetch(1'b0);

    // Misaligned jr halts; later inputs have no effect.
    do_instr(2'd3, 1'b0, 1'b0, 16'h0, 26'h0, 32'h0000_2002, 1'b0);
    for (int i = 0; i < 3; i++) begin
      ctrl_sel = 2'd0; instr_valid = 1'b1; imem_ack = 1'b1;
      @(negedge clk);
      chk1("halt_req", imem_req, 1'b0);
      chk("halt_pc", pc, m_pc);
      chk("halt_retired", retired, m_ret);
      chk1("halt_flag", jr_misalign, 1'b1);
    end
    instr_valid = 1'b0; imem_ack = 1'b0;

    // Reset pulse clears the sticky flag.
    rst_n = 1'b0;
    #1 chk1("rst_clears_flag", jr_misalign, 1'b0);
    chk("rst_pc_after_halt", pc, RPC);
    @(negedge clk);
    rst_n = 1'b1;
    m_pc = RPC; m_ret = 32'd0;
    exp_q.delete();
    exp_q.push_back(RPC);
    @(negedge clk);
    chk1("refetch_req", imem_req, 1'b1);
    do_fetch(1'b0);
    do_instr(2'd0, 1'b0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0);

    // Reset mid-FETCH: request drops in the same cycle.
    #2 rst_n = 1'b0;
    #1 chk1("midfetch_req", imem_req, 1'b0);
    chk("midfetch_pc", pc, RPC);
    @(negedge clk);
    rst_n = 1'b1;
    m_pc = RPC; m_ret = 32'd0;
    exp_q.delete();
    exp_q.push_back(RPC);
    #1 chk1("midfetch_idle", imem_req, 1'b0);
    @(negedge clk);
    chk1("midfetch_refetch", imem_req, 1'b1);
    do_fetch(1'b0);

    // Reset right after a JAL is accepted discards the link strobe.
    ctrl_sel = 2'd1; target26 = 26'h000_0010; link_en = 1'b1; instr_valid = 1'b1;
    @(posedge clk);
    #2 instr_valid = 1'b0; link_en = 1'b0; rst_n = 1'b0;
    #1 chk1("rst_discards_link", link_we, 1'b0);
    chk("rst_link_addr_clear", link_addr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
